// File: rtl/temp_monitor_multi.sv
// temp_monitor_multi: round-robin multi-channel ADC sampler with per-channel
// averaging, shift-add Celsius conversion (avg*5/16) and hysteresis alarms.
// A free-running divider produces sample ticks. Each tick taken in IDLE runs
// one SAMPLE round over all channels. After 2^AVG_LOG2 rounds, a CONVERT pass
// publishes one channel per cycle.
module temp_monitor_multi #(
  parameter int ADC_W      = 12,
  parameter int CHANNELS   = 4,
  parameter int AVG_LOG2   = 2,
  parameter int TEMP_W     = 16,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [CHANNELS*ADC_W-1:0]                             adc_value,
  input  logic [TEMP_W-1:0]                                     hi_thresh,
  input  logic [TEMP_W-1:0]                                     lo_thresh,
  output logic [CHANNELS*TEMP_W-1:0]                            temp_out,
  output logic                                                  temp_valid,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]    temp_ch,
  output logic [CHANNELS-1:0]                                   alarm,
  output logic                                                  any_alarm,
  output logic                                                  busy
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int RND_W = AVG_LOG2 + 1;
  localparam int SUM_W = ADC_W + 1;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [RND_W-1:0] ROUNDS     = RND_W'(1) << AVG_LOG2;
  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(CHANNELS - 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2
  } state_t;

  // State registers and their next-state values
  state_t                     state_q, state_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [RND_W-1:0]           round_q, round_d;
  logic [ACC_W-1:0]           acc_q [CHANNELS];
  logic [ACC_W-1:0]           acc_d [CHANNELS];
  logic [CHANNELS*TEMP_W-1:0] temp_out_q, temp_out_d;
  logic                       temp_valid_q, temp_valid_d;
  logic [CH_W-1:0]            temp_ch_q, temp_ch_d;
  logic [CHANNELS-1:0]        alarm_q, alarm_d;
  logic                       any_alarm_q, any_alarm_d;
  logic                       busy_q, busy_d;

  // Datapath helpers for the channel currently addressed by ch_q
  logic                       tick_s;
  logic [ADC_W-1:0]           sample_s;
  logic [ACC_W-1:0]           acc_cur_s;
  logic [ADC_W-1:0]           avg_s;
  logic [SUM_W-1:0]           sum_s;
  logic [TEMP_W-1:0]          temp_s;
  logic [RND_W-1:0]           round_inc_s;

  // Tick detection, selected-channel sample and the shift-add conversion
  always_comb begin
    tick_s      = (div_q == {DIV_W{1'b0}});
    sample_s    = adc_value[ch_q*ADC_W +: ADC_W];
    acc_cur_s   = acc_q[ch_q];
    avg_s       = ADC_W'(acc_cur_s >> AVG_LOG2);
    // avg + avg/4 fits in one extra bit; the final >>2 yields avg*5/16
    sum_s       = SUM_W'(avg_s) + SUM_W'(avg_s >> 2);
    temp_s      = TEMP_W'(sum_s >> 2);
    round_inc_s = round_q + RND_W'(1);
  end

  // Next-state logic: divider, sequencing FSM, accumulators and outputs
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    round_d      = round_q;
    acc_d        = acc_q;
    temp_out_d   = temp_out_q;
    temp_valid_d = 1'b0;
    temp_ch_d    = temp_ch_q;
    alarm_d      = alarm_q;
    any_alarm_d  = |alarm_q;

    if (tick_s) begin
      div_d = DIV_RELOAD;
    end else begin
      div_d = div_q - DIV_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        // Ticks are only honoured here; ticks seen while busy are dropped
        if (tick_s) begin
          state_d = ST_SAMPLE;
          ch_d    = {CH_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SAMPLE: begin
        acc_d[ch_q] = acc_cur_s + ACC_W'(sample_s);
        if (ch_q == LAST_CH) begin
          round_d = round_inc_s;
          ch_d    = {CH_W{1'b0}};
          if (round_inc_s == ROUNDS) begin
            state_d = ST_CONVERT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end

      ST_CONVERT: begin
        temp_out_d[ch_q*TEMP_W +: TEMP_W] = temp_s;
        temp_valid_d = 1'b1;
        temp_ch_d    = ch_q;
        // Set has priority so lo_thresh > hi_thresh still resolves cleanly
        if (temp_s >= hi_thresh) begin
          alarm_d[ch_q] = 1'b1;
        end else if (temp_s < lo_thresh) begin
          alarm_d[ch_q] = 1'b0;
        end else begin
          alarm_d[ch_q] = alarm_q[ch_q];
        end
        acc_d[ch_q] = {ACC_W{1'b0}};
        if (ch_q == LAST_CH) begin
          round_d = {RND_W{1'b0}};
          ch_d    = {CH_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        ch_d    = {CH_W{1'b0}};
        round_d = {RND_W{1'b0}};
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State update with synchronous reset; reset also restarts the divider
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      div_q        <= DIV_RELOAD;
      ch_q         <= {CH_W{1'b0}};
      round_q      <= {RND_W{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= {ACC_W{1'b0}};
      end
      temp_out_q   <= {(CHANNELS*TEMP_W){1'b0}};
      temp_valid_q <= 1'b0;
      temp_ch_q    <= {CH_W{1'b0}};
      alarm_q      <= {CHANNELS{1'b0}};
      any_alarm_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      ch_q         <= ch_d;
      round_q      <= round_d;
      acc_q        <= acc_d;
      temp_out_q   <= temp_out_d;
      temp_valid_q <= temp_valid_d;
      temp_ch_q    <= temp_ch_d;
      alarm_q      <= alarm_d;
      any_alarm_q  <= any_alarm_d;
      busy_q       <= busy_d;
    end
  end

  assign temp_out   = temp_out_q;
  assign temp_valid = temp_valid_q;
  assign temp_ch    = temp_ch_q;
  assign alarm      = alarm_q;
  assign any_alarm  = any_alarm_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_temp_monitor_multi.sv
// Directed bench for temp_monitor_multi: default configuration plus a fast
// instance (SAMPLE_DIV=CHANNELS+1, no averaging) sharing the same inputs.
module tb_temp_monitor_multi;

  localparam int ADC_W = 12;
  localparam int CH    = 4;
  localparam int TW    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [CH*ADC_W-1:0] adc_value;
  logic [TW-1:0]     hi_thresh;
  logic [TW-1:0]     lo_thresh;

  logic [CH*TW-1:0]  temp_out;
  logic              temp_valid;
  logic [1:0]        temp_ch;
  logic [CH-1:0]     alarm;
  logic              any_alarm;
  logic              busy;

  logic [CH*TW-1:0]  temp_out2;
  logic              temp_valid2;
  logic [1:0]        temp_ch2;
  logic [CH-1:0]     alarm2;
  logic              any_alarm2;
  logic              busy2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  temp_monitor_multi dut (
    .clk(clk), .reset(reset), .adc_value(adc_value),
    .hi_thresh(hi_thresh), .lo_thresh(lo_thresh),
    .temp_out(temp_out), .temp_valid(temp_valid), .temp_ch(temp_ch),
    .alarm(alarm), .any_alarm(any_alarm), .busy(busy)
  );

  temp_monitor_multi #(.ADC_W(12), .CHANNELS(4), .AVG_LOG2(0), .TEMP_W(16), .SAMPLE_DIV(5)) dut2 (
    .clk(clk), .reset(reset), .adc_value(adc_value),
    .hi_thresh(hi_thresh), .lo_thresh(lo_thresh),
    .temp_out(temp_out2), .temp_valid(temp_valid2), .temp_ch(temp_ch2),
    .alarm(alarm2), .any_alarm(any_alarm2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag, input int limit, output int n);
    n = 0;
    while (temp_valid !== 1'b1 && n < limit) begin
      step(1);
      n++;
    end
    check({tag, " valid_seen"}, {63'd0, temp_valid}, 64'd1);
  endtask

  // Checks a four-cycle result burst; alarm/any_alarm expectations follow the
  // slot-by-slot update order (any_alarm shows the OR of the previous cycle).
  task automatic burst(input string tag,
                       input logic [TW-1:0] e0, input logic [TW-1:0] e1,
                       input logic [TW-1:0] e2, input logic [TW-1:0] e3,
                       input logic [CH-1:0] a_old, input logic [CH-1:0] a_new);
    logic [TW-1:0] e [CH];
    logic [CH-1:0] a_prev;
    logic [CH-1:0] a_cur;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    a_prev = a_old;
    for (int k = 0; k < CH; k++) begin
      a_cur    = a_prev;
      a_cur[k] = a_new[k];
      check({tag, " valid"},     {63'd0, temp_valid}, 64'd1);
      check({tag, " ch"},        {62'd0, temp_ch}, 64'(k));
      check({tag, " temp"},      {48'd0, temp_out[k*TW +: TW]}, {48'd0, e[k]});
      check({tag, " alarm"},     {60'd0, alarm}, {60'd0, a_cur});
      check({tag, " any_alarm"}, {63'd0, any_alarm}, {63'd0, |a_prev});
      check({tag, " busy"},      {63'd0, busy}, (k != CH - 1) ? 64'd1 : 64'd0);
      a_prev = a_cur;
      step(1);
    end
    check({tag, " valid_end"},     {63'd0, temp_valid}, 64'd0);
    check({tag, " any_alarm_end"}, {63'd0, any_alarm}, {63'd0, |a_new});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " temp_out"},   temp_out, 64'd0);
    check({tag, " temp_valid"}, {63'd0, temp_valid}, 64'd0);
    check({tag, " temp_ch"},    {62'd0, temp_ch}, 64'd0);
    check({tag, " alarm"},      {60'd0, alarm}, 64'd0);
    check({tag, " any_alarm"},  {63'd0, any_alarm}, 64'd0);
    check({tag, " busy"},       {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int n;
    int cnt;
    int expch;
    logic [11:0] sweep_adc [6];
    logic        sweep_al  [6];
    logic        al_prev;
    logic [TW-1:0] sweep_t [6];

    sweep_adc[0] = 12'd819; sweep_t[0] = 16'd255; sweep_al[0] = 1'b0;
    sweep_adc[1] = 12'd869; sweep_t[1] = 16'd271; sweep_al[1] = 1'b0;
    sweep_adc[2] = 12'd919; sweep_t[2] = 16'd287; sweep_al[2] = 1'b0;
    sweep_adc[3] = 12'd969; sweep_t[3] = 16'd302; sweep_al[3] = 1'b1;
    sweep_adc[4] = 12'd929; sweep_t[4] = 16'd290; sweep_al[4] = 1'b1;
    sweep_adc[5] = 12'd869; sweep_t[5] = 16'd271; sweep_al[5] = 1'b0;

    reset     = 1'b1;
    adc_value = {12'd819, 12'd819, 12'd819, 12'd819};
    hi_thresh = 16'hFFFF;
    lo_thresh = 16'd0;
    step(3);
    check_reset_state("reset");

    // Cycle 0 is the first cycle with reset low
    reset = 1'b0;
    step(999);
    check("busy_before_tick", {63'd0, busy}, 64'd0);
    step(1);
    check("busy_first_sample", {63'd0, busy}, 64'd1);
    step(3);
    check("busy_last_sample", {63'd0, busy}, 64'd1);
    step(1);
    check("busy_after_round", {63'd0, busy}, 64'd0);

    // All channels 819 -> 255, first result at cycle 4005
    wait_valid("t1", 4100, n);
    check("t1 latency", 64'(n), 64'd3001);
    burst("t1", 16'd255, 16'd255, 16'd255, 16'd255, 4'b0000, 4'b0000);

    // Mixed levels including zero and full scale
    adc_value = {12'd820, 12'd4095, 12'd1600, 12'd0};
    wait_valid("t2", 4100, n);
    check("t2 period", 64'(n), 64'd3996);
    burst("t2", 16'd0, 16'd500, 16'd1279, 16'd256, 4'b0000, 4'b0000);

    // ch0 800,800,1600,1600 over four rounds -> avg 1200 -> 375
    adc_value = {12'd819, 12'd819, 12'd819, 12'd800};
    step(2000);
    adc_value = {12'd819, 12'd819, 12'd819, 12'd1600};
    wait_valid("t3", 4100, n);
    burst("t3", 16'd375, 16'd255, 16'd255, 16'd255, 4'b0000, 4'b0000);

    // Hysteresis sweep on ch1 with hi=300, lo=280; other channels at 0
    hi_thresh = 16'd300;
    lo_thresh = 16'd280;
    al_prev   = 1'b0;
    for (int s = 0; s < 6; s++) begin
      adc_value = {12'd0, 12'd0, sweep_adc[s], 12'd0};
      wait_valid("sweep", 4100, n);
      burst("sweep", 16'd0, sweep_t[s], 16'd0, 16'd0,
            {2'b00, al_prev, 1'b0}, {2'b00, sweep_al[s], 1'b0});
      al_prev = sweep_al[s];
    end

    // Reset in the middle of the third SAMPLE round
    adc_value = {12'd4095, 12'd4095, 12'd4095, 12'd4095};
    step(2992);
    check("busy_mid_sample", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    step(1);
    check_reset_state("midreset");
    adc_value = {12'd1600, 12'd1600, 12'd1600, 12'd1600};
    reset = 1'b0;
    wait_valid("post_reset", 4100, n);
    check("post_reset latency", 64'(n), 64'd4005);
    burst("post_reset", 16'd500, 16'd500, 16'd500, 16'd500, 4'b0000, 4'b1111);

    // Fast instance: align to a ch0 result, then every 10 cycles exactly one
    // four-slot burst in channel order
    n = 0;
    while (!(temp_valid2 === 1'b1 && temp_ch2 === 2'd0) && n < 20) begin
      step(1);
      n++;
    end
    check("fast align", {63'd0, temp_valid2}, 64'd1);
    cnt   = 0;
    expch = 0;
    for (int c = 0; c < 60; c++) begin
      if (temp_valid2 === 1'b1) begin
        check("fast ch", {62'd0, temp_ch2}, 64'(expch));
        check("fast temp", {48'd0, temp_out2[expch*TW +: TW]}, 64'd500);
        expch = (expch + 1) % CH;
        cnt++;
      end
      step(1);
    end
    check("fast count", 64'(cnt), 64'd24);
    check("fast alarm", {60'd0, alarm2}, 64'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
